// File: rtl/systolic_conv_sequencer_pkg.sv
// rtl/systolic_conv_sequencer_pkg.sv - shared types and flat-bus byte mapping for the conv sequencer
package systolic_conv_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_KICK   = 2'd1,
        ST_RUN    = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    localparam int IN_DIM   = 4;
    localparam int FIL_DIM  = 3;
    localparam int N_IN     = IN_DIM * IN_DIM;
    localparam int N_FIL    = FIL_DIM * FIL_DIM;
    localparam int N_BYTES  = N_IN + N_FIL;
    localparam int FIL_BASE = N_IN;
    localparam int IDX_W    = 5;

    // Byte slot of in(r,c) inside in_flat, 1-based row/column, row-major.
    function automatic int in_byte_idx(input int r, input int c);
        return IN_DIM * (r - 1) + (c - 1);
    endfunction

    // Byte slot of fil(r,c) inside fil_flat, 1-based row/column, row-major.
    function automatic int fil_byte_idx(input int r, input int c);
        return FIL_DIM * (r - 1) + (c - 1);
    endfunction

endpackage

// File: rtl/systolic_operand_regfile.sv
// rtl/systolic_operand_regfile.sv - 25x8 operand store presented as flat input/filter buses
module systolic_operand_regfile
    import systolic_conv_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [IDX_W-1:0]     idx,
    input  logic [7:0]           wdata,
    output logic [8*N_IN-1:0]    in_flat,
    output logic [8*N_FIL-1:0]   fil_flat
);

    logic [7:0] mem [N_BYTES];

    // Clear on reset, otherwise write one byte slot per accepted operand.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_BYTES; i++) begin
                mem[i] <= 8'd0;
            end
        end else if (we && (idx < IDX_W'(N_BYTES))) begin
            mem[idx] <= wdata;
        end
    end

    for (genvar g = 0; g < N_IN; g++) begin : g_in
        assign in_flat[8*g +: 8] = mem[g];
    end

    for (genvar g = 0; g < N_FIL; g++) begin : g_fil
        assign fil_flat[8*g +: 8] = mem[FIL_BASE + g];
    end

endmodule

// File: rtl/systolic_conv_sequencer.sv
// rtl/systolic_conv_sequencer.sv - loads operands, runs the 2x2 systolic array, returns one result word
module systolic_conv_sequencer
    import systolic_conv_sequencer_pkg::*;
#(
    parameter int COMPUTE_CYCLES = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    input  logic [7:0]           s_data,
    output logic                 s_ready,
    output logic [8*N_IN-1:0]    in_flat,
    output logic [8*N_FIL-1:0]   fil_flat,
    output logic                 array_rst,
    input  logic [7:0]           c11,
    input  logic [7:0]           c12,
    input  logic [7:0]           c21,
    input  logic [7:0]           c22,
    output logic                 res_valid,
    output logic [31:0]          res_data,
    input  logic                 res_ready,
    output logic                 busy
);

    localparam int                RUN_W    = 8;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_BYTES - 1);
    localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(COMPUTE_CYCLES - 1);

    state_t             state, state_nx;
    logic [IDX_W-1:0]   cnt, cnt_nx;
    logic [RUN_W-1:0]   run_cnt, run_cnt_nx;
    logic               array_rst_nx;
    logic               res_valid_nx;
    logic [31:0]        res_data_nx;
    logic               wr_en;

    systolic_operand_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (wr_en),
        .idx      (cnt),
        .wdata    (s_data),
        .in_flat  (in_flat),
        .fil_flat (fil_flat)
    );

    // Only the LOAD state takes bytes; every other state is a busy job.
    assign s_ready = (state == ST_LOAD);
    assign busy    = (state != ST_LOAD);

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_LOAD;
            cnt       <= '0;
            run_cnt   <= '0;
            array_rst <= 1'b1;
            res_valid <= 1'b0;
            res_data  <= 32'd0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            run_cnt   <= run_cnt_nx;
            array_rst <= array_rst_nx;
            res_valid <= res_valid_nx;
            res_data  <= res_data_nx;
        end
    end

    // Next-state logic: load bytes, one kick cycle, fixed compute window, hold result.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        run_cnt_nx   = run_cnt;
        array_rst_nx = array_rst;
        res_valid_nx = res_valid;
        res_data_nx  = res_data;
        wr_en        = 1'b0;

        unique case (state)
            ST_LOAD: begin
                array_rst_nx = 1'b1;
                if (s_valid) begin
                    wr_en = 1'b1;
                    if (cnt == LAST_IDX) begin
                        cnt_nx   = '0;
                        state_nx = ST_KICK;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            ST_KICK: begin
                // array_rst is still high this cycle, so the array restarts on the new operands.
                array_rst_nx = 1'b0;
                run_cnt_nx   = '0;
                state_nx     = ST_RUN;
            end
            ST_RUN: begin
                if (run_cnt == RUN_LAST) begin
                    res_data_nx  = {c11, c12, c21, c22};
                    res_valid_nx = 1'b1;
                    // Result is captured, so the array can be parked in reset again.
                    array_rst_nx = 1'b1;
                    state_nx     = ST_RESULT;
                end else begin
                    run_cnt_nx = run_cnt + 1'b1;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    res_valid_nx = 1'b0;
                    array_rst_nx = 1'b1;
                    state_nx     = ST_LOAD;
                end
            end
            default: begin
                state_nx = ST_LOAD;
            end
        endcase
    end

endmodule

// File: tb/tb_systolic_conv_sequencer.sv
// tb/tb_systolic_conv_sequencer.sv - scoreboard bench with an array model for the conv sequencer
module tb_systolic_conv_sequencer;
    import systolic_conv_sequencer_pkg::*;

    localparam int CC = 18;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         s_valid = 1'b0;
    logic [7:0]   s_data = 8'd0;
    logic         s_ready;
    logic [127:0] in_flat;
    logic [71:0]  fil_flat;
    logic         array_rst;
    logic [7:0]   c11, c12, c21, c22;
    logic         res_valid;
    logic [31:0]  res_data;
    logic         res_ready = 1'b0;
    logic         busy;

    int errors = 0;
    int checks = 0;
    logic [31:0] sb [$];
    int cur_hold = 0;

    always #5 clk = ~clk;

    systolic_conv_sequencer #(.COMPUTE_CYCLES(CC)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .in_flat(in_flat), .fil_flat(fil_flat), .array_rst(array_rst),
        .c11(c11), .c12(c12), .c21(c21), .c22(c22),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready), .busy(busy)
    );

    // Reference: 2x2 valid convolution of the job's byte list, 8-bit wrap, c11 in the top byte.
    function automatic logic [31:0] model(input logic [7:0] b [25]);
        int img [4][4];
        int f [3][3];
        int acc;
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < 16; i++) img[i/4][i%4] = b[i];
        for (int i = 0; i < 9; i++) f[i/3][i%3] = b[16+i];
        for (int oi = 0; oi < 2; oi++) begin
            for (int oj = 0; oj < 2; oj++) begin
                acc = 0;
                for (int r2 = 0; r2 < 3; r2++)
                    for (int c2 = 0; c2 < 3; c2++)
                        acc += img[oi+r2][oj+c2] * f[r2][c2];
                r[31-8*(2*oi+oj) -: 8] = acc[7:0];
            end
        end
        return r;
    endfunction

    // Array stand-in: reads the flat buses, valid only after 17 cycles out of reset.
    function automatic logic [31:0] arr_conv(input logic [127:0] ib, input logic [71:0] fb);
        int acc;
        int ii, fi;
        logic [31:0] r;
        r = 32'd0;
        for (int oi = 1; oi <= 2; oi++) begin
            for (int oj = 1; oj <= 2; oj++) begin
                acc = 0;
                for (int r2 = 1; r2 <= 3; r2++) begin
                    for (int c2 = 1; c2 <= 3; c2++) begin
                        ii = in_byte_idx(oi + r2 - 1, oj + c2 - 1);
                        fi = fil_byte_idx(r2, c2);
                        acc += int'(ib[8*ii +: 8]) * int'(fb[8*fi +: 8]);
                    end
                end
                r[31-8*(2*(oi-1)+(oj-1)) -: 8] = acc[7:0];
            end
        end
        return r;
    endfunction

    int acnt = 0;
    logic [31:0] arr_v;
    always @(posedge clk) begin
        if (array_rst) acnt <= 0;
        else if (acnt < 1000) acnt <= acnt + 1;
    end
    always_comb arr_v = arr_conv(in_flat, fil_flat);
    assign {c11, c12, c21, c22} = (acnt >= 17) ? arr_v : ~arr_v;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Downstream: hold res_ready low for cur_hold cycles of res_valid, then accept.
    int wcnt = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (res_valid) begin
                res_ready = (wcnt >= cur_hold);
                wcnt++;
            end else begin
                res_ready = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on each result handshake and checks protocol rules.
    logic         p_valid = 1'b0;
    logic         p_hs = 1'b0;
    logic [31:0]  p_data = 32'd0;
    logic         p_arst = 1'b1;
    logic [127:0] p_in = '0;
    logic [71:0]  p_fil = '0;
    int           lowcnt = 0;
    logic [31:0]  exp_w;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                p_valid = 1'b0; p_hs = 1'b0; p_arst = 1'b1; lowcnt = 0;
            end else begin
                chk("s_ready_vs_busy", 128'(s_ready), 128'(!busy));
                if (!array_rst) begin
                    lowcnt++;
                    if (!p_arst) begin
                        chk("in_flat_stable_in_run", in_flat, p_in);
                        chk("fil_flat_stable_in_run", 128'(fil_flat), 128'(p_fil));
                    end
                end else if (lowcnt != 0) begin
                    chk("array_rst_low_cycles", 128'(lowcnt), 128'(CC));
                    lowcnt = 0;
                end
                if (p_hs) chk("res_valid_drop", 128'(res_valid), 128'(0));
                if (res_valid && p_valid && !p_hs) chk("res_data_stable", 128'(res_data), 128'(p_data));
                if (res_valid && res_ready) begin
                    if (sb.size() == 0) begin
                        errors++; checks++;
                        $display("FAIL unexpected_result: got %h expected none", res_data);
                    end else begin
                        exp_w = sb.pop_front();
                        chk("res_data", 128'(res_data), 128'(exp_w));
                    end
                end
                p_valid = res_valid;
                p_hs    = res_valid && res_ready;
                p_data  = res_data;
                p_arst  = array_rst;
                p_in    = in_flat;
                p_fil   = fil_flat;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit done;
        done = 1'b0;
        if (gap > 0) begin
            s_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
        s_valid = 1'b1;
        s_data  = b;
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge clk);
            if (s_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            errors++; checks++;
            $display("FAIL byte_accept_timeout: got s_ready=0 expected 1 within 400 cycles");
        end
    endtask

    task automatic send_job(input logic [7:0] b [25], input int maxgap, input int hold);
        cur_hold = hold;
        for (int k = 0; k < 25; k++) begin
            send_byte(b[k], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        end
        sb.push_back(model(b));
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 3000 && sb.size() != 0; t++) @(posedge clk);
        if (sb.size() != 0) begin
            errors++; checks++;
            $display("FAIL result_timeout: got %0d pending expected 0", sb.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [7:0] job [25];

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_s_ready", 128'(s_ready), 128'(1));
        chk("rst_in_flat", in_flat, 128'(0));
        chk("rst_fil_flat", 128'(fil_flat), 128'(0));
        chk("rst_array_rst", 128'(array_rst), 128'(1));
        chk("rst_res_valid", 128'(res_valid), 128'(0));
        chk("rst_res_data", 128'(res_data), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        @(posedge clk);
        #1;

        // Inputs 1..16, all-ones filter.
        for (int k = 0; k < 25; k++) job[k] = (k < 16) ? 8'(k + 1) : 8'd1;
        send_job(job, 0, 0);
        // Centre tap only.
        for (int k = 0; k < 25; k++) job[k] = (k < 16) ? 8'(k + 1) : 8'd0;
        job[16 + fil_byte_idx(2, 2)] = 8'd1;
        send_job(job, 0, 0);
        // Wrapping sums.
        for (int k = 0; k < 25; k++) job[k] = (k < 16) ? 8'd30 : 8'd1;
        send_job(job, 0, 0);
        // First job again with gaps and a slow consumer.
        for (int k = 0; k < 25; k++) job[k] = (k < 16) ? 8'(k + 1) : 8'd1;
        send_job(job, 3, 10);
        s_valid = 1'b0;
        wait_idle();

        // Partial job discarded by reset.
        for (int k = 0; k < 10; k++) send_byte(8'($urandom_range(1, 255)), 0);
        s_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midjob_rst_in_flat", in_flat, 128'(0));
        chk("midjob_rst_s_ready", 128'(s_ready), 128'(1));
        @(posedge clk);
        #1;
        for (int k = 0; k < 25; k++) job[k] = 8'($urandom);
        send_job(job, 0, 0);

        // Back-to-back random jobs, bytes offered continuously or with small gaps.
        for (int j = 0; j < 6; j++) begin
            for (int k = 0; k < 25; k++) job[k] = 8'($urandom);
            send_job(job, (j % 2 == 0) ? 0 : 2, int'($urandom_range(0, 3)));
        end
        s_valid = 1'b0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
